// File: rtl/regfile_ctrl.sv
// Command sequencer for a 2**AW x DW register file: WRITE, READ, COPY and CLEAR,
// one command at a time (no queueing), one registered completion pulse per command.
module regfile_ctrl #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_dst,
   input  logic [AW-1:0] cmd_src,
   input  logic [DW-1:0] cmd_data,
   input  logic          wr_lock,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_err,
   output logic [AW-1:0] rf_address_a,
   output logic [AW-1:0] rf_address_b,
   output logic          rf_write,
   output logic          rf_mode,
   output logic [DW-1:0] rf_write_data,
   input  logic [DW-1:0] rf_out
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WR      = 3'd1;
   localparam logic [2:0] ST_RD_ADDR = 3'd2;
   localparam logic [2:0] ST_RD_DATA = 3'd3;
   localparam logic [2:0] ST_CP_WR   = 3'd4;
   localparam logic [2:0] ST_CLR     = 3'd5;
   localparam logic [2:0] ST_RESP    = 3'd6;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_COPY  = 2'b10;

   localparam logic [AW-1:0] CNT_MAX = '1;

   logic [2:0]    r_state;
   logic [1:0]    r_op;
   logic [AW-1:0] r_dst;
   logic [AW-1:0] r_clr_cnt;
   logic          r_cmd_ready;
   logic          r_rsp_valid;
   logic [DW-1:0] r_rsp_data;
   logic          r_rsp_err;
   logic [AW-1:0] r_rf_address_a;
   logic [AW-1:0] r_rf_address_b;
   logic          r_rf_write;
   logic          r_rf_mode;
   logic [DW-1:0] r_rf_write_data;

   logic          w_accept;
   logic          w_locked;

   assign w_accept = cmd_valid && r_cmd_ready;
   assign w_locked = wr_lock && (cmd_op != OP_READ);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_op            <= OP_WRITE;
         r_dst           <= '0;
         r_clr_cnt       <= '0;
         r_cmd_ready     <= 1'b0;
         r_rsp_valid     <= 1'b0;
         r_rsp_data      <= '0;
         r_rsp_err       <= 1'b0;
         r_rf_address_a  <= '0;
         r_rf_address_b  <= '0;
         r_rf_write      <= 1'b0;
         r_rf_mode       <= 1'b0;
         r_rf_write_data <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_rf_write  <= 1'b0;
         r_cmd_ready <= 1'b0;
         r_rf_mode   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_cmd_ready <= 1'b1;
               if (w_accept) begin
                  r_cmd_ready <= 1'b0;
                  r_op        <= cmd_op;
                  r_dst       <= cmd_dst;
                  if (w_locked) begin
                     r_state     <= ST_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= '0;
                     r_rsp_err   <= 1'b1;
                  end else begin
                     case (cmd_op)
                        OP_WRITE: begin
                           r_state         <= ST_WR;
                           r_rf_address_a  <= cmd_dst;
                           r_rf_write      <= 1'b1;
                           r_rf_write_data <= cmd_data;
                        end
                        OP_READ, OP_COPY: begin
                           r_state        <= ST_RD_ADDR;
                           r_rf_address_b <= cmd_src;
                        end
                        default: begin
                           r_state         <= ST_CLR;
                           r_clr_cnt       <= '0;
                           r_rf_address_a  <= '0;
                           r_rf_write      <= 1'b1;
                           r_rf_write_data <= '0;
                        end
                     endcase
                  end
               end
            end
            // rf_write_data still holds the written word, so it doubles as response data
            ST_WR: begin
               r_state     <= ST_RESP;
               r_rsp_valid <= 1'b1;
               r_rsp_data  <= r_rf_write_data;
               r_rsp_err   <= 1'b0;
            end
            ST_RD_ADDR: begin
               r_state <= ST_RD_DATA;
            end
            ST_RD_DATA: begin
               if (r_op == OP_COPY) begin
                  r_state         <= ST_CP_WR;
                  r_rf_address_a  <= r_dst;
                  r_rf_write      <= 1'b1;
                  r_rf_write_data <= rf_out;
               end else begin
                  r_state     <= ST_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= rf_out;
                  r_rsp_err   <= 1'b0;
               end
            end
            ST_CP_WR: begin
               r_state     <= ST_RESP;
               r_rsp_valid <= 1'b1;
               r_rsp_data  <= r_rf_write_data;
               r_rsp_err   <= 1'b0;
            end
            ST_CLR: begin
               if (r_clr_cnt == CNT_MAX) begin
                  r_state     <= ST_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b0;
               end else begin
                  r_clr_cnt      <= r_clr_cnt + 1'b1;
                  r_rf_address_a <= r_clr_cnt + 1'b1;
                  r_rf_write     <= 1'b1;
               end
            end
            ST_RESP: begin
               r_state     <= ST_IDLE;
               r_cmd_ready <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready     = r_cmd_ready;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_data      = r_rsp_data;
   assign rsp_err       = r_rsp_err;
   assign rf_address_a  = r_rf_address_a;
   assign rf_address_b  = r_rf_address_b;
   assign rf_write      = r_rf_write;
   assign rf_mode       = r_rf_mode;
   assign rf_write_data = r_rf_write_data;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: behavioural register file plus directed command table
// and hand-written reset-abort and back-to-back sequences.
module tb_regfile_ctrl;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_dst;
   logic [4:0]  cmd_src;
   logic [31:0] cmd_data;
   logic        wr_lock;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [4:0]  rf_address_a;
   logic [4:0]  rf_address_b;
   logic        rf_write;
   logic        rf_mode;
   logic [31:0] rf_write_data;
   logic [31:0] rf_out;

   int checks = 0;
   int errors = 0;

   regfile_ctrl #(.DW(32), .AW(5)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_data(cmd_data), .wr_lock(wr_lock),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .rf_address_a(rf_address_a), .rf_address_b(rf_address_b), .rf_write(rf_write),
      .rf_mode(rf_mode), .rf_write_data(rf_write_data), .rf_out(rf_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file: synchronous write when mode is 0, read data one clock after address
   logic [31:0] mem [32];
   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      rf_out = 32'h0;
   end
   always @(posedge clk) begin
      if (rf_write === 1'b1 && rf_mode === 1'b0) mem[rf_address_a] <= rf_write_data;
      rf_out <= mem[rf_address_b];
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Issues one command at a negedge and follows it to its response
   task automatic do_cmd(input string name, input logic [1:0] op, input logic [4:0] dst,
                         input logic [4:0] src, input logic [31:0] data, input logic lock,
                         input int exp_lat, input int exp_nwr, input int exp_wcyc,
                         input logic [4:0] exp_waddr, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
      int          w;
      int          lat;
      int          nwr;
      int          wbad;
      logic [31:0] rdata;
      logic        rerr;
      w = 0;
      while (cmd_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (cmd_ready !== 1'b1) check({name, "_ready_wait"}, 32'(cmd_ready), 32'h1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_dst   = dst;
      cmd_src   = src;
      cmd_data  = data;
      wr_lock   = lock;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_dst   = 5'($urandom);
      cmd_src   = 5'($urandom);
      cmd_data  = $urandom;
      wr_lock   = 1'($urandom);
      lat   = 0;
      nwr   = 0;
      wbad  = 0;
      rdata = 32'hx;
      rerr  = 1'bx;
      for (int n = 1; n <= 60; n++) begin
         if (rf_write === 1'b1) begin
            nwr++;
            if (n != exp_wcyc + nwr - 1 ||
                32'(rf_address_a) != 32'(exp_waddr) + 32'(nwr) - 32'd1 ||
                rf_write_data !== exp_wdata) wbad++;
         end
         if (rsp_valid === 1'b1) begin
            lat   = n;
            rdata = rsp_data;
            rerr  = rsp_err;
            break;
         end
         @(negedge clk);
      end
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_nwrites"}, 32'(nwr), 32'(exp_nwr));
      check({name, "_write_seq"}, 32'(wbad), 32'h0);
      check({name, "_rsp_data"}, rdata, exp_rdata);
      check({name, "_rsp_err"}, 32'(rerr), 32'(exp_err));
      @(negedge clk);
      check({name, "_pulse"}, 32'(rsp_valid), 32'h0);
      check({name, "_idle_ready"}, 32'(cmd_ready), 32'h1);
      check({name, "_idle_nowrite"}, 32'(rf_write), 32'h0);
      check({name, "_rf_mode"}, 32'(rf_mode), 32'h0);
      check({name, "_rsp_hold"}, rsp_data, exp_rdata);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [4:0]  dst;
      logic [4:0]  src;
      logic [31:0] data;
      logic        lock;
      int          lat;
      int          nwr;
      int          wcyc;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t tv [16];

   initial begin
      int prev_acc;
      int nacc;
      int nrsp;
      int sbad;
      int dbad;

      // op, dst, src, data, lock, lat, nwr, wcyc, waddr, wdata, rdata, err
      tv[0]  = '{2'd1, 5'd0,  5'd4,  32'h0,        1'b0, 3,  0,  0, 5'd0, 32'h0,        32'h1000_0004, 1'b0};
      tv[1]  = '{2'd0, 5'd5,  5'd0,  32'hDEADBEEF, 1'b0, 2,  1,  1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
      tv[2]  = '{2'd1, 5'd0,  5'd5,  32'h0,        1'b0, 3,  0,  0, 5'd0, 32'h0,        32'hDEADBEEF, 1'b0};
      tv[3]  = '{2'd0, 5'd7,  5'd0,  32'h12345678, 1'b0, 2,  1,  1, 5'd7, 32'h12345678, 32'h12345678, 1'b0};
      tv[4]  = '{2'd2, 5'd9,  5'd7,  32'h0,        1'b0, 4,  1,  3, 5'd9, 32'h12345678, 32'h12345678, 1'b0};
      tv[5]  = '{2'd1, 5'd0,  5'd9,  32'h0,        1'b0, 3,  0,  0, 5'd0, 32'h0,        32'h12345678, 1'b0};
      tv[6]  = '{2'd2, 5'd9,  5'd9,  32'h0,        1'b0, 4,  1,  3, 5'd9, 32'h12345678, 32'h12345678, 1'b0};
      tv[7]  = '{2'd0, 5'd3,  5'd0,  32'hFFFFFFFF, 1'b1, 1,  0,  0, 5'd0, 32'h0,        32'h0,         1'b1};
      tv[8]  = '{2'd1, 5'd0,  5'd3,  32'h0,        1'b1, 3,  0,  0, 5'd0, 32'h0,        32'h1000_0003, 1'b0};
      tv[9]  = '{2'd2, 5'd3,  5'd7,  32'h0,        1'b1, 1,  0,  0, 5'd0, 32'h0,        32'h0,         1'b1};
      tv[10] = '{2'd1, 5'd0,  5'd3,  32'h0,        1'b0, 3,  0,  0, 5'd0, 32'h0,        32'h1000_0003, 1'b0};
      tv[11] = '{2'd3, 5'd0,  5'd0,  32'h0,        1'b1, 1,  0,  0, 5'd0, 32'h0,        32'h0,         1'b1};
      tv[12] = '{2'd1, 5'd0,  5'd20, 32'h0,        1'b0, 3,  0,  0, 5'd0, 32'h0,        32'h1000_0014, 1'b0};
      tv[13] = '{2'd3, 5'd0,  5'd0,  32'h0,        1'b0, 33, 32, 1, 5'd0, 32'h0,        32'h0,         1'b0};
      tv[14] = '{2'd1, 5'd0,  5'd31, 32'h0,        1'b0, 3,  0,  0, 5'd0, 32'h0,        32'h0,         1'b0};
      tv[15] = '{2'd1, 5'd0,  5'd9,  32'h0,        1'b0, 3,  0,  0, 5'd0, 32'h0,        32'h0,         1'b0};

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_dst = 5'd0; cmd_src = 5'd0;
      cmd_data = 32'h0; wr_lock = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_data", rsp_data, 32'h0);
      check("rst_rsp_err", 32'(rsp_err), 32'h0);
      check("rst_rf_write", 32'(rf_write), 32'h0);
      check("rst_rf_mode", 32'(rf_mode), 32'h0);
      check("rst_rf_addr_a", 32'(rf_address_a), 32'h0);
      check("rst_rf_addr_b", 32'(rf_address_b), 32'h0);
      check("rst_rf_wdata", rf_write_data, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_release_ready", 32'(cmd_ready), 32'h1);

      for (int i = 0; i < 32; i++)
         do_cmd($sformatf("fill%0d", i), 2'd0, 5'(i), 5'd0, 32'h1000_0000 + 32'(i), 1'b0,
                2, 1, 1, 5'(i), 32'h1000_0000 + 32'(i), 32'h1000_0000 + 32'(i), 1'b0);

      for (int v = 0; v < 16; v++)
         do_cmd($sformatf("vec%0d", v), tv[v].op, tv[v].dst, tv[v].src, tv[v].data, tv[v].lock,
                tv[v].lat, tv[v].nwr, tv[v].wcyc, tv[v].waddr, tv[v].wdata, tv[v].rdata, tv[v].err);

      // Reset in the tenth CLEAR cycle: addresses 0..9 cleared, 10 untouched
      do_cmd("pre9", 2'd0, 5'd9, 5'd0, 32'h0000_0099, 1'b0, 2, 1, 1, 5'd9, 32'h99, 32'h99, 1'b0);
      do_cmd("pre10", 2'd0, 5'd10, 5'd0, 32'h0A0A_0A0A, 1'b0, 2, 1, 1, 5'd10, 32'h0A0A_0A0A,
             32'h0A0A_0A0A, 1'b0);
      cmd_valid = 1'b1; cmd_op = 2'd3; wr_lock = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("abort_c10_write", 32'(rf_write), 32'h1);
      check("abort_c10_addr", 32'(rf_address_a), 32'h9);
      rst = 1'b1;
      @(negedge clk);
      check("abort_rf_write", 32'(rf_write), 32'h0);
      check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
      check("abort_addr_a", 32'(rf_address_a), 32'h0);
      check("abort_cmd_ready", 32'(cmd_ready), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_ready_after", 32'(cmd_ready), 32'h1);
      check("abort_no_rsp", 32'(rsp_valid), 32'h0);
      check("abort_no_write", 32'(rf_write), 32'h0);
      check("abort_rsp_data", rsp_data, 32'h0);
      do_cmd("post_abort9", 2'd1, 5'd0, 5'd9, 32'h0, 1'b0, 3, 0, 0, 5'd0, 32'h0, 32'h0, 1'b0);
      do_cmd("post_abort10", 2'd1, 5'd0, 5'd10, 32'h0, 1'b0, 3, 0, 0, 5'd0, 32'h0,
             32'h0A0A_0A0A, 1'b0);

      // cmd_valid held high with READs: accepts every 4th cycle
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_src = 5'd10; wr_lock = 1'b1;
      prev_acc = -1; nacc = 0; nrsp = 0; sbad = 0; dbad = 0;
      for (int c = 0; c < 20; c++) begin
         if (cmd_ready === 1'b1) begin
            nacc++;
            if (prev_acc >= 0 && c - prev_acc != 4) sbad++;
            prev_acc = c;
         end
         if (rsp_valid === 1'b1) begin
            nrsp++;
            if (rsp_data !== 32'h0A0A_0A0A || rsp_err !== 1'b0) dbad++;
         end
         if (c < 19) @(negedge clk);
      end
      cmd_valid = 1'b0;
      check("b2b_accepts", 32'(nacc), 32'd5);
      check("b2b_responses", 32'(nrsp), 32'd5);
      check("b2b_spacing", 32'(sbad), 32'd0);
      check("b2b_data", 32'(dbad), 32'd0);
      @(negedge clk);
      check("b2b_idle_rsp", 32'(rsp_valid), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
